packet_slot_buffer: RTL and testbench

PACKET_SLOT_BUFFER -- requirements
Module: packet_slot_buffer

---
 rtl/packet_slot_buffer.sv | 180 ++++++++++++++++++
 tb/tb_packet_slot_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_slot_buffer.sv
// ============================================================================
// packet_slot_buffer : ring FIFO of packet slots, byte-masked writes, word reads
// Optional PACKET_SLOT_BUFFER_STATS_EN adds saturating sent/drop counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module packet_slot_buffer #(
    parameter int slot_p       = 4,
    parameter int data_width_p = 64,
    parameter int els_p        = 2048,
    localparam int AW = $clog2(els_p),
    localparam int SW = $clog2(els_p + 1),
    localparam int BW = $clog2($clog2(data_width_p / 8) + 1),
    localparam int OW = $clog2(slot_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    output logic                    packet_avail_o,
    input  logic                    packet_ack_i,
    input  logic                    packet_rvalid_i,
    input  logic [AW-1:0]           packet_raddr_i,
    output logic [data_width_p-1:0] packet_rdata_o,
    output logic [SW-1:0]           packet_rsize_o,
    output logic                    packet_req_o,
    input  logic                    packet_send_i,
    input  logic                    packet_drop_i,
    input  logic                    packet_wsize_valid_i,
    input  logic [SW-1:0]           packet_wsize_i,
    input  logic                    packet_wvalid_i,
    input  logic [AW-1:0]           packet_waddr_i,
    input  logic [data_width_p-1:0] packet_wdata_i,
    input  logic [BW-1:0]           packet_wdata_size_i,
    output logic [OW-1:0]           occupancy_o,
    output logic                    error_o
`ifdef PACKET_SLOT_BUFFER_STATS_EN
    ,
    output logic [31:0]             sent_count_o,
    output logic [31:0]             drop_count_o
`endif
);

    localparam int BYTES = data_width_p / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int WORDS = els_p / BYTES;
    localparam int DEPTH = slot_p * WORDS;
    localparam int MW    = $clog2(DEPTH);
    localparam int PW    = $clog2(slot_p);

    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OW-1:0]           occ_q, occ_d;
    logic                    error_q, error_d;
    logic [SW-1:0]           size_q [slot_p];
    logic [SW-1:0]           size_d [slot_p];
    logic [data_width_p-1:0] rdata_q;
    logic [data_width_p-1:0] mem_q [DEPTH];

    logic          w_enq, w_deq, w_drop, w_rd, w_rd_err;
    logic          w_wsz, w_wsz_err, w_wr, w_wr_err;
    logic          w_bsize_ok, w_aligned;
    logic [LB:0]   w_nbytes;
    logic [LB-1:0] w_woff;
    logic [BYTES-1:0] w_lane;
    logic [MW-1:0] w_widx, w_ridx;

    assign packet_avail_o = (occ_q != '0);
    assign packet_req_o   = (occ_q != OW'(slot_p));
    assign occupancy_o    = occ_q;
    assign error_o        = error_q;
    assign packet_rdata_o = rdata_q;
    assign packet_rsize_o = size_q[rptr_q];

    // Drop wins over send; a full ring cannot accept either.
    assign w_drop = packet_drop_i & packet_req_o;
    assign w_enq  = packet_send_i & packet_req_o & ~packet_drop_i;
    assign w_deq  = packet_ack_i & packet_avail_o;

    assign w_rd     = packet_rvalid_i & packet_avail_o;
    assign w_rd_err = w_rd & (packet_raddr_i[LB-1:0] != '0);
    assign w_ridx   = MW'(rptr_q) * MW'(WORDS) + MW'(packet_raddr_i >> LB);

    assign w_wsz     = packet_wsize_valid_i & packet_req_o;
    assign w_wsz_err = w_wsz & (packet_wsize_i > SW'(els_p));

    assign w_bsize_ok = (packet_wdata_size_i <= BW'(LB));
    assign w_nbytes   = (LB + 1)'(1) << packet_wdata_size_i;
    assign w_woff     = packet_waddr_i[LB-1:0];
    assign w_aligned  = ((w_woff & (w_nbytes[LB-1:0] - LB'(1))) == '0);
    assign w_wr       = packet_wvalid_i & packet_req_o & w_bsize_ok & w_aligned;
    assign w_wr_err   = packet_wvalid_i & packet_req_o & ~(w_bsize_ok & w_aligned);
    assign w_widx     = MW'(wptr_q) * MW'(WORDS) + MW'(packet_waddr_i >> LB);

    always_comb begin
        w_lane = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_lane[b] = ((LB + 1)'(b) >= {1'b0, w_woff}) &&
                        ((LB + 1)'(b) <  ({1'b0, w_woff} + w_nbytes));
        end
    end

    always_comb begin
        wptr_d  = wptr_q + PW'(w_enq);
        rptr_d  = rptr_q + PW'(w_deq);
        error_d = error_q | w_wr_err | w_wsz_err | w_rd_err;
        occ_d   = occ_q;
        case ({w_enq, w_deq})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        for (int i = 0; i < slot_p; i++) begin
            size_d[i] = size_q[i];
        end
        if (w_drop) begin
            size_d[wptr_q] = '0;
        end else if (w_wsz && !w_wsz_err) begin
            size_d[wptr_q] = packet_wsize_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            error_q <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < slot_p; i++) begin
                size_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            error_q <= error_d;
            for (int i = 0; i < slot_p; i++) begin
                size_q[i] <= size_d[i];
            end
            // Misaligned reads still return the containing word.
            if (w_rd) begin
                rdata_q <= mem_q[w_ridx];
            end
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_lane[b]) begin
                    mem_q[w_widx][8*b +: 8] <= packet_wdata_i[8*b +: 8];
                end
            end
        end
    end

`ifdef PACKET_SLOT_BUFFER_STATS_EN
    logic [31:0] sent_q, drop_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (w_enq && (sent_q != '1)) begin
                sent_q <= sent_q + 32'd1;
            end
            if (w_drop && (drop_q != '1)) begin
                drop_q <= drop_q + 32'd1;
            end
        end
    end

    assign sent_count_o = sent_q;
    assign drop_count_o = drop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_slot_buffer.sv
// ============================================================================
// tb_packet_slot_buffer : scenario-driven bench with a read-data scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_packet_slot_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        avail, ack, rvalid, req, send, drop, wsize_valid, wvalid, error;
    logic [10:0] raddr, waddr;
    logic [63:0] rdata, wdata;
    logic [11:0] rsize, wsize;
    logic [1:0]  wdata_size;
    logic [2:0]  occupancy;
`ifdef PACKET_SLOT_BUFFER_STATS_EN
    logic [31:0] sent_count, drop_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    packet_slot_buffer dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .packet_avail_o      (avail),
        .packet_ack_i        (ack),
        .packet_rvalid_i     (rvalid),
        .packet_raddr_i      (raddr),
        .packet_rdata_o      (rdata),
        .packet_rsize_o      (rsize),
        .packet_req_o        (req),
        .packet_send_i       (send),
        .packet_drop_i       (drop),
        .packet_wsize_valid_i(wsize_valid),
        .packet_wsize_i      (wsize),
        .packet_wvalid_i     (wvalid),
        .packet_waddr_i      (waddr),
        .packet_wdata_i      (wdata),
        .packet_wdata_size_i (wdata_size),
        .occupancy_o         (occupancy),
        .error_o             (error)
`ifdef PACKET_SLOT_BUFFER_STATS_EN
        ,
        .sent_count_o        (sent_count),
        .drop_count_o        (drop_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ack = 0; rvalid = 0; raddr = '0; send = 0; drop = 0;
        wsize_valid = 0; wsize = '0; wvalid = 0; waddr = '0; wdata = '0; wdata_size = '0;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [63:0] d, input logic [1:0] sz);
        wvalid = 1; waddr = a; wdata = d; wdata_size = sz;
        tick();
        wvalid = 0;
    endtask

    task automatic do_send;
        send = 1;
        tick();
        send = 0;
    endtask

    task automatic do_ack;
        ack = 1;
        tick();
        ack = 0;
    endtask

    // Expected word is queued at request time; the test pops it after the edge.
    task automatic issue_read(input logic [10:0] a, input logic [63:0] exp);
        exp_q.push_back(exp);
        rvalid = 1; raddr = a;
        tick();
        rvalid = 0;
    endtask

    task automatic pulse_reset;
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_reset;
        idle();
        reset_n = 0;
        repeat (3) tick();
        reset_n = 1;
        tick();
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL reset_avail got=%0b exp=0", avail); end
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL reset_req got=%0b exp=1", req); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error); end
        checks++; if (rsize !== 12'd0) begin failures++; $display("FAIL reset_rsize got=%0d exp=0", rsize); end
        checks++; if (rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    endtask

    task automatic test_fill;
        int e;
        send = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = (i + 1 > 4) ? 4 : i + 1;
            checks++; if (occupancy !== 3'(e)) begin failures++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, occupancy, e); end
        end
        send = 0;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL fill_req got=%0b exp=0", req); end
        checks++; if (avail !== 1'b1) begin failures++; $display("FAIL fill_avail got=%0b exp=1", avail); end
        ack = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = (3 - i < 0) ? 0 : 3 - i;
            checks++; if (occupancy !== 3'(e)) begin failures++; $display("FAIL drain_occ[%0d] got=%0d exp=%0d", i, occupancy, e); end
        end
        ack = 0;
        checks++; if (req !== 1'b1 || avail !== 1'b0) begin failures++; $display("FAIL drain_flags got=req%0b/avail%0b exp=req1/avail0", req, avail); end
    endtask

    task automatic test_data_size;
        logic [63:0] exp;
        wvalid = 1; waddr = 11'h10; wdata = 64'h1122334455667788; wdata_size = 2'd3;
        wsize_valid = 1; wsize = 12'd60;
        tick();
        wvalid = 0; wsize_valid = 0;
        do_send();
        checks++; if (rsize !== 12'd60) begin failures++; $display("FAIL data_rsize got=%0d exp=60", rsize); end
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL data_occ got=%0d exp=1", occupancy); end
        issue_read(11'h10, 64'h1122334455667788);
        exp = exp_q.pop_front();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL data_read got=%h exp=%h", rdata, exp); end
        repeat (2) tick();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL data_hold got=%h exp=%h", rdata, exp); end
        do_ack();
    endtask

    task automatic test_byte_mask;
        logic [63:0] exp;
        do_write(11'h10, 64'h0, 2'd3);
        do_write(11'h13, 64'hABABABABABABABAB, 2'd0);
        do_write(11'h18, 64'h0, 2'd3);
        do_write(11'h1C, 64'h5A5A5A5A5A5A5A5A, 2'd0);
        do_send();
        exp_q.push_back(64'h00000000AB000000);
        exp_q.push_back(64'h0000005A00000000);
        rvalid = 1; raddr = 11'h10;
        tick();
        exp = exp_q.pop_front();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL mask_read0 got=%h exp=%h", rdata, exp); end
        raddr = 11'h18;
        tick();
        rvalid = 0;
        exp = exp_q.pop_front();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL mask_read1 got=%h exp=%h", rdata, exp); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL mask_error got=%0b exp=0", error); end
        do_ack();
    endtask

    task automatic test_drop;
        wsize_valid = 1; wsize = 12'd100;
        tick();
        wsize_valid = 0;
        checks++; if (rsize !== 12'd100) begin failures++; $display("FAIL drop_presize got=%0d exp=100", rsize); end
        send = 1; drop = 1;
        tick();
        send = 0; drop = 0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL drop_occ got=%0d exp=0", occupancy); end
        checks++; if (rsize !== 12'd0) begin failures++; $display("FAIL drop_cleared got=%0d exp=0", rsize); end
        do_send();
        checks++; if (occupancy !== 3'd1 || rsize !== 12'd0) begin failures++; $display("FAIL drop_next got=occ%0d/size%0d exp=occ1/size0", occupancy, rsize); end
        do_ack();
    endtask

    task automatic test_error;
        logic [63:0] exp;
        do_write(11'h0, 64'h0, 2'd3);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_pre got=%0b exp=0", error); end
        do_write(11'h2, 64'hFFFFFFFFFFFFFFFF, 2'd2);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", error); end
        do_send();
        issue_read(11'h0, 64'h0);
        exp = exp_q.pop_front();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL err_mem got=%h exp=%h", rdata, exp); end
        repeat (3) tick();
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", error); end
        do_ack();
        pulse_reset();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", error); end
    endtask

    task automatic test_read_misalign;
        logic [63:0] exp;
        do_send();
        issue_read(11'h11, 64'h1122334455667788);
        exp = exp_q.pop_front();
        checks++; if (rdata !== exp) begin failures++; $display("FAIL misalign_data got=%h exp=%h", rdata, exp); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL misalign_err got=%0b exp=1", error); end
        pulse_reset();
    endtask

    task automatic test_size_error;
        wsize_valid = 1; wsize = 12'd50;
        tick();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL sizeerr_pre got=%0b exp=0", error); end
        wsize = 12'd2049;
        tick();
        wsize_valid = 0;
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL sizeerr_set got=%0b exp=1", error); end
        do_send();
        checks++; if (rsize !== 12'd50) begin failures++; $display("FAIL sizeerr_keep got=%0d exp=50", rsize); end
        pulse_reset();
    endtask

    task automatic test_full_ack_send;
        repeat (4) do_send();
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
        ack = 1; send = 1;
        tick();
        ack = 0; send = 0;
        checks++; if (occupancy !== 3'd3 || req !== 1'b1) begin failures++; $display("FAIL full_acksend got=occ%0d/req%0b exp=occ3/req1", occupancy, req); end
        repeat (2) do_send();
        #2;
        reset_n = 0;
        #1;
        checks++; if (occupancy !== 3'd0 || avail !== 1'b0 || req !== 1'b1) begin failures++; $display("FAIL async_reset got=occ%0d/avail%0b/req%0b exp=occ0/avail0/req1", occupancy, avail, req); end
        tick();
        reset_n = 1;
        do_send();
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL post_reset got=%0d exp=1", occupancy); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_data_size();
        test_byte_mask();
        test_drop();
        test_error();
        test_read_misalign();
        test_size_error();
        test_full_ack_send();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
